// File: rtl/udt_axis_pkg.sv
// Shared types and lane helpers for the byte-reversing AXI-Stream pipe.
// Helpers work on MAX_BYTES-wide vectors; callers zero-extend and truncate to their lane count.
package udt_axis_pkg;

  localparam int DATA_BYTES_DEF = 8;
  localparam int MAX_BYTES      = 64;

  typedef enum logic {SOP = 1'b0, MID = 1'b1} mode_state_t;

  typedef logic [8*MAX_BYTES-1:0] lane_data_t;
  typedef logic [MAX_BYTES-1:0]   lane_keep_t;

  // Byte lane i of the result takes lane n-1-i of d; lanes >= n are zero.
  function automatic lane_data_t lane_rev(input lane_data_t d, input int n);
    lane_data_t r;
    int         j;
    r = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      j = (i < n) ? (n - 1 - i) : i;
      r[8*i +: 8] = (i < n) ? d[8*j +: 8] : 8'h00;
    end
    return r;
  endfunction

  function automatic lane_keep_t keep_rev(input lane_keep_t k, input int n);
    lane_keep_t r;
    int         j;
    r = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      j = (i < n) ? (n - 1 - i) : i;
      r[i] = (i < n) ? k[j] : 1'b0;
    end
    return r;
  endfunction

  // Non-zero run of ones starting at lane 0 (hi=0) or at lane n-1 (hi=1).
  function automatic logic keep_contig(input lane_keep_t k, input int n, input logic hi);
    lane_keep_t e;
    e = hi ? keep_rev(k, n) : k;
    return (e != '0) && ((e & (e + lane_keep_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/axis_byte_reverse_pipe_if.sv
// AXI-Stream beat bundle (tdata/tkeep/tlast with valid/ready) for the byte-reverse pipe.
interface axis_byte_reverse_pipe_if
  import udt_axis_pkg::*;
#(
  parameter int DATA_BYTES = DATA_BYTES_DEF
);
  logic [8*DATA_BYTES-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer: registered push_ready and pop side, full throughput, order preserved.
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_valid,
  output logic             push_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  input  logic             pop_ready
);

  logic [WIDTH-1:0] skid_data, main_d_n, skid_d_n;
  logic             skid_vld, main_vld_n, skid_vld_n;
  logic             push, main_free;

  assign push      = push_valid & push_ready;
  assign main_free = !pop_valid | pop_ready;

  always_comb begin
    main_vld_n = pop_valid;
    main_d_n   = pop_data;
    skid_vld_n = skid_vld;
    skid_d_n   = skid_data;
    if (main_free) begin
      // Skid holds the older beat, so it always drains into main first.
      if (skid_vld) begin
        main_vld_n = 1'b1;
        main_d_n   = skid_data;
        skid_vld_n = push;
        if (push) skid_d_n = push_data;
      end else begin
        main_vld_n = push;
        if (push) main_d_n = push_data;
      end
    end else if (push) begin
      skid_vld_n = 1'b1;
      skid_d_n   = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_valid  <= 1'b0;
      pop_data   <= '0;
      skid_vld   <= 1'b0;
      skid_data  <= '0;
      push_ready <= 1'b0;
    end else begin
      pop_valid  <= main_vld_n;
      pop_data   <= main_d_n;
      skid_vld   <= skid_vld_n;
      skid_data  <= skid_d_n;
      push_ready <= !skid_vld_n;
    end
  end

endmodule

// File: rtl/axis_byte_reverse_pipe.sv
// Per-packet byte-lane reverse/bypass in front of a skid buffer, with beat/packet counters
// and a sticky tkeep-shape error flag.
module axis_byte_reverse_pipe
  import udt_axis_pkg::*;
#(
  parameter int DATA_BYTES = DATA_BYTES_DEF,
  parameter int CNT_W      = 32
) (
  input  logic                         core_clk,
  input  logic                         core_rst,
  input  logic                         swap_en,
  axis_byte_reverse_pipe_if.slave      src,
  axis_byte_reverse_pipe_if.master     snk,
  output logic [CNT_W-1:0]             pkt_cnt,
  output logic [CNT_W-1:0]             beat_cnt,
  output logic                         keep_err
);

  localparam int DW = 8*DATA_BYTES;
  localparam int W  = DW + DATA_BYTES + 1;
  localparam logic [DATA_BYTES-1:0] KEEP_ONES = '1;

  mode_state_t             state, state_nxt;
  logic                    mode_q, mode_eff;
  logic                    in_rdy, push, keep_bad;
  logic [DW-1:0]           data_x;
  logic [DATA_BYTES-1:0]   keep_x;
  logic [W-1:0]            pop_data;

  assign src.tready = in_rdy;
  assign push       = src.tvalid & in_rdy;

  // First beat takes swap_en live; later beats use the value latched at SOP.
  assign mode_eff = (state == SOP) ? swap_en : mode_q;

  always_comb begin
    data_x   = src.tdata;
    keep_x   = src.tkeep;
    if (mode_eff) begin
      data_x = DW'(lane_rev(lane_data_t'(src.tdata), DATA_BYTES));
      keep_x = DATA_BYTES'(keep_rev(lane_keep_t'(src.tkeep), DATA_BYTES));
    end
    keep_bad = src.tlast ? !keep_contig(lane_keep_t'(src.tkeep), DATA_BYTES, mode_eff)
                         : (src.tkeep != KEEP_ONES);
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) state <= SOP;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (push) state_nxt = src.tlast ? SOP : MID;
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      mode_q   <= 1'b0;
      pkt_cnt  <= '0;
      beat_cnt <= '0;
      keep_err <= 1'b0;
    end else if (push) begin
      if (state == SOP) mode_q <= swap_en;
      beat_cnt <= beat_cnt + CNT_W'(1);
      if (src.tlast) pkt_cnt <= pkt_cnt + CNT_W'(1);
      if (keep_bad)  keep_err <= 1'b1;
    end
  end

  axis_skid_buf #(.WIDTH(W)) u_skid (
    .clk        (core_clk),
    .rst        (core_rst),
    .push_data  ({src.tlast, keep_x, data_x}),
    .push_valid (src.tvalid),
    .push_ready (in_rdy),
    .pop_data   (pop_data),
    .pop_valid  (snk.tvalid),
    .pop_ready  (snk.tready)
  );

  assign {snk.tlast, snk.tkeep, snk.tdata} = pop_data;

endmodule
